// File: rtl/avalon_pio_in_irq.sv
// Avalon-MM input PIO: per-bit synchroniser, optional debounce, edge capture
// with write-1-to-clear, interrupt mask and a registered level interrupt.
`timescale 1ns/1ps

module avalon_pio_in_irq #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CNT_W   = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int PRIME_W = $clog2(SYNC_STAGES + 2);
  localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0]   sync_out;
  logic [WIDTH-1:0]   filtered;
  logic [WIDTH-1:0]   filtered_d_reg;
  logic [WIDTH-1:0]   rise_bits;
  logic [WIDTH-1:0]   fall_bits;
  logic [WIDTH-1:0]   edge_raw;
  logic [WIDTH-1:0]   event_bits;
  logic [WIDTH-1:0]   clear_bits;
  logic [WIDTH-1:0]   edge_capture_reg;
  logic [WIDTH-1:0]   edge_capture_next;
  logic [WIDTH-1:0]   irq_mask_reg;
  logic [PRIME_W-1:0] prime_reg;
  logic               primed;
  logic               wr_en;
  logic [31:0]        read_next;
  logic [31:0]        readdata_reg;
  logic               irq_reg;
  logic               unused_wdata;

  assign unused_wdata = ^writedata;
  assign wr_en        = chipselect & ~write_n;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [SYNC_STAGES-1:0] sync_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_reg <= '0;
        else          sync_reg <= {sync_reg[SYNC_STAGES-2:0], in_port[gi]};
      end
      assign sync_out[gi] = sync_reg[SYNC_STAGES-1];

      if (DEBOUNCE_CYCLES == 0) begin : g_nodb
        assign filtered[gi] = sync_out[gi];
      end else begin : g_db
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
        logic [CNT_W-1:0] cnt_reg;
        logic             filt_reg;

        // The filtered bit only follows sync_out after DEBOUNCE_CYCLES
        // consecutive cycles of disagreement.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            cnt_reg  <= '0;
            filt_reg <= 1'b0;
          end else if (sync_out[gi] == filt_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            filt_reg <= sync_out[gi];
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        assign filtered[gi] = filt_reg;
      end
    end
  endgenerate

  // Edge events stay masked until the synchroniser has flushed its reset
  // contents, so pins already high at reset do not look like edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prime_reg      <= '0;
      filtered_d_reg <= '0;
    end else begin
      if (prime_reg != PRIME_DONE) prime_reg <= prime_reg + PRIME_W'(1);
      filtered_d_reg <= filtered;
    end
  end

  assign primed    = (prime_reg == PRIME_DONE);
  assign rise_bits = filtered & ~filtered_d_reg;
  assign fall_bits = ~filtered & filtered_d_reg;

  always_comb begin
    edge_raw = rise_bits | fall_bits;
    if (EDGE_TYPE == 0)      edge_raw = rise_bits;
    else if (EDGE_TYPE == 1) edge_raw = fall_bits;
  end

  assign event_bits = primed ? edge_raw : '0;
  assign clear_bits = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  // A new event on the same cycle as a clear keeps the bit set.
  assign edge_capture_next = (edge_capture_reg & ~clear_bits) | event_bits;

  always_comb begin
    read_next = '0;
    case (address)
      2'd0:    read_next[WIDTH-1:0] = filtered;
      2'd2:    read_next[WIDTH-1:0] = irq_mask_reg;
      2'd3:    read_next[WIDTH-1:0] = edge_capture_reg;
      default: read_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_reg     <= '0;
      edge_capture_reg <= '0;
      readdata_reg     <= '0;
      irq_reg          <= 1'b0;
    end else begin
      if (wr_en && address == 2'd2) irq_mask_reg <= writedata[WIDTH-1:0];
      edge_capture_reg <= edge_capture_next;
      readdata_reg     <= read_next;
      irq_reg          <= |(edge_capture_reg & irq_mask_reg);
    end
  end

  assign readdata = readdata_reg;
  assign irq      = irq_reg;

endmodule
